cinema_booking_engine: RTL and testbench

Parametrised multi-theater seat booking engine with a valid/ready request port and a fixed-latency response.
- Adds a HOLD→CONFIRM flow with per-seat hold timeout.
- Stores the price paid per seat, so cancellations refund exactly that price.
- Adds a QUERY operation.
- Sits between the ticketing front-end controller and the revenue/reporting logic.

---
 rtl/cinema_booking_engine.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_cinema_booking_engine.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cinema_booking_engine.sv
// Multi-theater seat booking engine.
// Accepts one request at a time over a valid/ready port, prices it in a dedicated
// cycle, commits it to the seat map and strobes a registered response two cycles
// after acceptance. Held seats carry a countdown timer and fall back to FREE when
// it runs out, unless a CONFIRM/CANCEL for that seat commits on the same edge.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      request handshake
//   req_op                     00 HOLD, 01 CONFIRM, 10 CANCEL, 11 QUERY
//   req_theater/row/col        seat address (row/col carry one extra bit for range errors)
//   req_category/slot/day      pricing inputs
//   resp_valid                 one-cycle response strobe
//   resp_status/state/price    result code, seat state after the op, quoted/charged/refunded price
//   total_booked/held/revenue  aggregate counters across all theaters
//   hold_expired               one-cycle pulse when at least one hold times out
module cinema_booking_engine #(
  parameter int unsigned NUM_THEATERS = 4,
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned PRICE_W      = 16,
  parameter int unsigned HOLD_CYCLES  = 16,
  localparam int unsigned ThW  = (NUM_THEATERS > 1) ? $clog2(NUM_THEATERS) : 1,
  localparam int unsigned RowW = $clog2(ROWS) + 1,
  localparam int unsigned ColW = $clog2(COLS) + 1,
  localparam int unsigned CntW = $clog2(NUM_THEATERS * ROWS * COLS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [ThW-1:0]     req_theater,
  input  logic [RowW-1:0]    req_row,
  input  logic [ColW-1:0]    req_col,
  input  logic [1:0]         req_category,
  input  logic [1:0]         req_slot,
  input  logic [1:0]         req_day,
  output logic               resp_valid,
  output logic [2:0]         resp_status,
  output logic [1:0]         resp_state,
  output logic [PRICE_W-1:0] resp_price,
  output logic [CntW-1:0]    total_booked,
  output logic [CntW-1:0]    total_held,
  output logic [PRICE_W-1:0] total_revenue,
  output logic               hold_expired
);

  localparam int unsigned NumSeats = NUM_THEATERS * ROWS * COLS;
  localparam int unsigned SeatW    = (NumSeats > 1) ? $clog2(NumSeats) : 1;
  localparam int unsigned TmrW     = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] OpHold    = 2'b00;
  localparam logic [1:0] OpConfirm = 2'b01;
  localparam logic [1:0] OpCancel  = 2'b10;
  localparam logic [1:0] OpQuery   = 2'b11;

  localparam logic [2:0] StatOk        = 3'd0;
  localparam logic [2:0] StatRange     = 3'd1;
  localparam logic [2:0] StatNotFree   = 3'd2;
  localparam logic [2:0] StatNotHeld   = 3'd3;
  localparam logic [2:0] StatNotBooked = 3'd4;
  localparam logic [2:0] StatCat       = 3'd5;

  typedef enum logic [1:0] {StIdle, StPrice, StCommit} fsm_e;
  typedef enum logic [1:0] {SeatFree = 2'b00, SeatHeld = 2'b01, SeatBooked = 2'b10} seat_e;

  // ---------------------------------------------------------------- FSM
  fsm_e state_q, state_d;
  logic accept, commit;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign commit    = (state_q == StCommit);

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = StPrice;
      StPrice:  state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------- request capture
  logic [1:0]      op_q, cat_q, slot_q, day_q;
  logic [ThW-1:0]  th_q;
  logic [RowW-1:0] row_q;
  logic [ColW-1:0] col_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      th_q   <= '0;
      row_q  <= '0;
      col_q  <= '0;
      cat_q  <= '0;
      slot_q <= '0;
      day_q  <= '0;
    end else if (accept) begin
      op_q   <= req_op;
      th_q   <= req_theater;
      row_q  <= req_row;
      col_q  <= req_col;
      cat_q  <= req_category;
      slot_q <= req_slot;
      day_q  <= req_day;
    end
  end

  // ---------------------------------------------------------------- pricing
  // Multipliers are percentages, so the product is scaled back by 100*100.
  logic [31:0]        base, slot_m, day_m, prod;
  logic [PRICE_W-1:0] price_calc, price_q;

  always_comb begin
    case (cat_q)
      2'd0:    base = 32'd150;
      2'd1:    base = 32'd200;
      2'd2:    base = 32'd300;
      default: base = 32'd0;
    endcase
    case (slot_q)
      2'd0:    slot_m = 32'd80;
      2'd2:    slot_m = 32'd120;
      default: slot_m = 32'd100;
    endcase
    case (day_q)
      2'd1:    day_m = 32'd120;
      2'd2:    day_m = 32'd150;
      default: day_m = 32'd100;
    endcase
    prod       = base * slot_m * day_m;
    price_calc = PRICE_W'(prod / 32'd10000);
  end

  always_ff @(posedge clk) begin
    if (reset)                    price_q <= '0;
    else if (state_q == StPrice)  price_q <= price_calc;
  end

  // ---------------------------------------------------------------- seat map
  seat_e              seat_state_q [NumSeats];
  logic [PRICE_W-1:0] seat_price_q [NumSeats];
  logic [TmrW-1:0]    seat_timer_q [NumSeats];

  logic               in_range;
  logic [SeatW-1:0]   seat_idx;
  seat_e              cur_state;
  logic [PRICE_W-1:0] cur_price;

  assign in_range  = (32'(row_q) < ROWS) && (32'(col_q) < COLS);
  assign seat_idx  = SeatW'(32'(th_q) * (ROWS * COLS) + 32'(row_q) * COLS + 32'(col_q));
  assign cur_state = seat_state_q[seat_idx];
  assign cur_price = seat_price_q[seat_idx];

  // Commit decode: seat write plus counter deltas.
  logic               seat_we;
  seat_e              new_state;
  logic [PRICE_W-1:0] new_price;
  logic [TmrW-1:0]    new_timer;
  logic               held_inc, held_dec, booked_inc, booked_dec;
  logic [PRICE_W-1:0] rev_add, rev_sub;
  logic [2:0]         cmt_status;
  seat_e              cmt_state;
  logic [PRICE_W-1:0] cmt_price;

  always_comb begin
    seat_we    = 1'b0;
    new_state  = cur_state;
    new_price  = cur_price;
    new_timer  = '0;
    held_inc   = 1'b0;
    held_dec   = 1'b0;
    booked_inc = 1'b0;
    booked_dec = 1'b0;
    rev_add    = '0;
    rev_sub    = '0;
    cmt_status = StatOk;
    cmt_state  = cur_state;
    cmt_price  = '0;
    if (commit) begin
      if (!in_range) begin
        cmt_status = StatRange;
        cmt_state  = SeatFree;
      end else begin
        unique case (op_q)
          OpHold: begin
            if (cat_q == 2'b11) begin
              cmt_status = StatCat;
            end else if (cur_state != SeatFree) begin
              cmt_status = StatNotFree;
            end else begin
              seat_we   = 1'b1;
              new_state = SeatHeld;
              new_price = price_q;
              new_timer = TmrW'(HOLD_CYCLES);
              held_inc  = 1'b1;
              cmt_state = SeatHeld;
              cmt_price = price_q;
            end
          end
          OpConfirm: begin
            if (cur_state != SeatHeld) begin
              cmt_status = StatNotHeld;
            end else begin
              seat_we    = 1'b1;
              new_state  = SeatBooked;
              held_dec   = 1'b1;
              booked_inc = 1'b1;
              rev_add    = cur_price;
              cmt_state  = SeatBooked;
              cmt_price  = cur_price;
            end
          end
          OpCancel: begin
            if (cur_state == SeatBooked) begin
              seat_we    = 1'b1;
              new_state  = SeatFree;
              booked_dec = 1'b1;
              rev_sub    = cur_price;
              cmt_state  = SeatFree;
              cmt_price  = cur_price;
            end else if (cur_state == SeatHeld) begin
              seat_we   = 1'b1;
              new_state = SeatFree;
              held_dec  = 1'b1;
              cmt_state = SeatFree;
            end else begin
              cmt_status = StatNotBooked;
            end
          end
          OpQuery: begin
            cmt_price = (cur_state == SeatFree) ? '0 : cur_price;
          end
          default: ;
        endcase
      end
    end
  end

  // A seat written by the commit this edge is excluded: the request wins the race.
  logic [NumSeats-1:0] expire_vec;
  logic [CntW-1:0]     expire_cnt;

  always_comb begin
    expire_vec = '0;
    expire_cnt = '0;
    for (int i = 0; i < NumSeats; i++) begin
      expire_vec[i] = (seat_state_q[i] == SeatHeld) && (seat_timer_q[i] == TmrW'(1)) &&
                      !(seat_we && (seat_idx == SeatW'(i)));
      expire_cnt    = expire_cnt + CntW'(expire_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumSeats; i++) begin
        seat_state_q[i] <= SeatFree;
        seat_price_q[i] <= '0;
        seat_timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumSeats; i++) begin
        if (seat_we && (seat_idx == SeatW'(i))) begin
          seat_state_q[i] <= new_state;
          seat_price_q[i] <= new_price;
          seat_timer_q[i] <= new_timer;
        end else if (seat_state_q[i] == SeatHeld) begin
          if (expire_vec[i]) begin
            seat_state_q[i] <= SeatFree;
            seat_timer_q[i] <= '0;
          end else begin
            seat_timer_q[i] <= seat_timer_q[i] - TmrW'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- counters and response
  logic [CntW-1:0]    total_booked_q, total_held_q;
  logic [PRICE_W-1:0] total_revenue_q;
  logic               resp_valid_q, hold_expired_q;
  logic [2:0]         resp_status_q;
  logic [1:0]         resp_state_q;
  logic [PRICE_W-1:0] resp_price_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      total_booked_q  <= '0;
      total_held_q    <= '0;
      total_revenue_q <= '0;
      resp_valid_q    <= 1'b0;
      resp_status_q   <= '0;
      resp_state_q    <= '0;
      resp_price_q    <= '0;
      hold_expired_q  <= 1'b0;
    end else begin
      total_booked_q  <= total_booked_q + CntW'(booked_inc) - CntW'(booked_dec);
      total_held_q    <= total_held_q + CntW'(held_inc) - CntW'(held_dec) - expire_cnt;
      total_revenue_q <= total_revenue_q + rev_add - rev_sub;
      resp_valid_q    <= commit;
      hold_expired_q  <= (expire_cnt != '0);
      if (commit) begin
        resp_status_q <= cmt_status;
        resp_state_q  <= cmt_state;
        resp_price_q  <= cmt_price;
      end
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_status   = resp_status_q;
  assign resp_state    = resp_state_q;
  assign resp_price    = resp_price_q;
  assign total_booked  = total_booked_q;
  assign total_held    = total_held_q;
  assign total_revenue = total_revenue_q;
  assign hold_expired  = hold_expired_q;

endmodule

// File: tb/tb_cinema_booking_engine.sv
// Bench for cinema_booking_engine: directed scenarios followed by random requests,
// all checked every cycle against a seat-map model that tracks holds by absolute
// expiry cycle rather than by countdown.
module tb_cinema_booking_engine;

  localparam int NT = 4;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int PW = 16;
  localparam int HC = 16;
  localparam int NSEATS = NT * ROWS * COLS;
  localparam int CW = $clog2(NSEATS + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [1:0]    req_theater = '0;
  logic [3:0]    req_row = '0;
  logic [3:0]    req_col = '0;
  logic [1:0]    req_category = '0;
  logic [1:0]    req_slot = '0;
  logic [1:0]    req_day = '0;
  logic          resp_valid;
  logic [2:0]    resp_status;
  logic [1:0]    resp_state;
  logic [PW-1:0] resp_price;
  logic [CW-1:0] total_booked;
  logic [CW-1:0] total_held;
  logic [PW-1:0] total_revenue;
  logic          hold_expired;

  cinema_booking_engine #(
    .NUM_THEATERS(NT), .ROWS(ROWS), .COLS(COLS), .PRICE_W(PW), .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_theater(req_theater), .req_row(req_row), .req_col(req_col),
    .req_category(req_category), .req_slot(req_slot), .req_day(req_day),
    .resp_valid(resp_valid), .resp_status(resp_status), .resp_state(resp_state),
    .resp_price(resp_price), .total_booked(total_booked), .total_held(total_held),
    .total_revenue(total_revenue), .hold_expired(hold_expired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  longint cyc = 0;

  // Model: 0 FREE, 1 HELD, 2 BOOKED
  int          m_state [NSEATS];
  logic [15:0] m_price [NSEATS];
  longint      m_deadline [NSEATS];
  int          m_held, m_booked;
  logic [15:0] m_rev;

  int p_op, p_th, p_row, p_col, p_cat, p_slot, p_day;
  bit          exp_resp;
  int          exp_status, exp_state;
  logic [15:0] exp_price;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_price(input int cat, input int slot, input int day);
    int b[4];
    int s[4];
    int d[4];
    b = '{150, 200, 300, 0};
    s = '{80, 100, 120, 100};
    d = '{100, 120, 150, 100};
    return 16'((b[cat] * s[slot] * d[day]) / 10000);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NSEATS; i++) begin
      m_state[i] = 0;
      m_price[i] = '0;
      m_deadline[i] = 0;
    end
    m_held = 0;
    m_booked = 0;
    m_rev = '0;
  endfunction

  task automatic model_apply();
    int idx;
    int cur;
    exp_resp = 1'b1;
    exp_status = 0;
    exp_price = '0;
    if (p_row >= ROWS || p_col >= COLS) begin
      exp_status = 1;
      exp_state = 0;
      return;
    end
    idx = p_th * ROWS * COLS + p_row * COLS + p_col;
    cur = m_state[idx];
    exp_state = cur;
    case (p_op)
      0: begin
        if (p_cat == 3) exp_status = 5;
        else if (cur != 0) exp_status = 2;
        else begin
          m_state[idx] = 1;
          m_price[idx] = model_price(p_cat, p_slot, p_day);
          m_deadline[idx] = cyc + HC;
          m_held++;
          exp_state = 1;
          exp_price = m_price[idx];
        end
      end
      1: begin
        if (cur != 1) exp_status = 3;
        else begin
          m_state[idx] = 2;
          m_held--;
          m_booked++;
          m_rev = m_rev + m_price[idx];
          exp_state = 2;
          exp_price = m_price[idx];
        end
      end
      2: begin
        if (cur == 2) begin
          m_state[idx] = 0;
          m_booked--;
          m_rev = m_rev - m_price[idx];
          exp_state = 0;
          exp_price = m_price[idx];
        end else if (cur == 1) begin
          m_state[idx] = 0;
          m_held--;
          exp_state = 0;
        end else exp_status = 4;
      end
      default: exp_price = (cur == 0) ? 16'd0 : m_price[idx];
    endcase
  endtask

  // One clock edge; cmt marks the edge on which the outstanding request commits.
  task automatic step(input bit cmt);
    int n;
    @(posedge clk);
    cyc++;
    exp_resp = 1'b0;
    if (cmt) model_apply();
    n = 0;
    for (int i = 0; i < NSEATS; i++) begin
      if (m_state[i] == 1 && m_deadline[i] == cyc) begin
        m_state[i] = 0;
        m_held--;
        n++;
      end
    end
    #1;
    if (hold_expired === 1'b1) pulse_cnt++;
    chk("resp_valid", resp_valid, exp_resp);
    if (exp_resp) begin
      chk("resp_status", resp_status, exp_status);
      chk("resp_state", resp_state, exp_state);
      chk("resp_price", resp_price, exp_price);
    end
    chk("hold_expired", hold_expired, n > 0);
    chk("total_held", total_held, m_held);
    chk("total_booked", total_booked, m_booked);
    chk("total_revenue", total_revenue, m_rev);
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    model_clear();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_held", total_held, 0);
    chk("rst_booked", total_booked, 0);
    chk("rst_revenue", total_revenue, 0);
    chk("rst_hold_expired", hold_expired, 0);
  endtask

  task automatic do_req(input int op, input int th, input int row, input int col,
                        input int cat, input int slot, input int day);
    chk("req_ready_idle", req_ready, 1);
    p_op = op; p_th = th; p_row = row; p_col = col; p_cat = cat; p_slot = slot; p_day = day;
    req_op = 2'(op);
    req_theater = 2'(th);
    req_row = 4'(row);
    req_col = 4'(col);
    req_category = 2'(cat);
    req_slot = 2'(slot);
    req_day = 2'(day);
    req_valid = 1'b1;
    step(1'b0);
    req_valid = 1'b0;
    chk("req_ready_busy", req_ready, 0);
    step(1'b0);
    chk("req_ready_commit", req_ready, 0);
    step(1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    model_clear();
    do_reset();

    // Premium evening weekday: 200*120*100/10000 = 240
    do_req(0, 1, 2, 3, 1, 2, 0);
    chk("t1_hold_price", resp_price, 240);
    chk("t1_hold_state", resp_state, 1);
    do_req(1, 1, 2, 3, 0, 0, 0);
    chk("t1_conf_state", resp_state, 2);
    chk("t1_booked", total_booked, 1);
    chk("t1_revenue", total_revenue, 240);

    // Hold expiry
    do_reset();
    do_req(0, 0, 0, 0, 0, 1, 0);
    pulse_cnt = 0;
    for (int i = 0; i < HC; i++) step(1'b0);
    chk("t2_pulses", pulse_cnt, 1);
    chk("t2_held", total_held, 0);
    do_req(1, 0, 0, 0, 0, 1, 0);
    chk("t2_conf_status", resp_status, 3);

    // VIP morning holiday: 300*80*150/10000 = 360, refunded in full
    do_reset();
    do_req(0, 2, 4, 4, 2, 0, 2);
    chk("t3_price", resp_price, 360);
    do_req(1, 2, 4, 4, 0, 1, 0);
    do_req(2, 2, 4, 4, 0, 1, 0);
    chk("t3_refund", resp_price, 360);
    chk("t3_revenue", total_revenue, 0);
    chk("t3_state", resp_state, 0);

    // Error cases
    do_req(0, 0, 1, 1, 0, 1, 0);
    do_req(0, 0, 1, 1, 0, 1, 0);
    chk("t4_not_free", resp_status, 2);
    chk("t4_not_free_price", resp_price, 0);
    do_req(0, 0, 1, 2, 3, 1, 0);
    chk("t4_cat", resp_status, 5);
    do_req(0, 0, ROWS, 2, 0, 1, 0);
    chk("t4_range", resp_status, 1);
    do_req(2, 3, 0, 7, 0, 1, 0);
    chk("t4_not_booked", resp_status, 4);

    // Independent theaters
    do_reset();
    do_req(0, 0, 5, 6, 0, 1, 0);
    do_req(0, 3, 5, 6, 0, 1, 0);
    chk("t5_held", total_held, 2);
    do_req(3, 2, 5, 6, 0, 1, 0);
    chk("t5_query_state", resp_state, 0);
    chk("t5_query_price", resp_price, 0);
    do_req(3, 3, 5, 6, 0, 1, 0);
    chk("t5_query_held_price", resp_price, 150);

    // CONFIRM commits on the edge where the timer would expire
    do_reset();
    do_req(0, 1, 1, 1, 0, 1, 0);
    for (int i = 0; i < HC - 3; i++) step(1'b0);
    pulse_cnt = 0;
    do_req(1, 1, 1, 1, 0, 1, 0);
    chk("t6_status", resp_status, 0);
    chk("t6_state", resp_state, 2);
    chk("t6_no_pulse", pulse_cnt, 0);
    chk("t6_held", total_held, 0);

    // Reset while the request sits in PRICE
    do_req(0, 0, 3, 3, 1, 1, 1);
    req_op = 2'd0; req_theater = 2'd0; req_row = 4'd2; req_col = 4'd2;
    req_category = 2'd0; req_slot = 2'd1; req_day = 2'd0;
    req_valid = 1'b1;
    step(1'b0);
    req_valid = 1'b0;
    do_reset();
    step(1'b0);
    chk("t7_ready", req_ready, 1);

    // Random traffic on a small seat window so collisions and expiries happen
    for (int k = 0; k < 400; k++) begin
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) step(1'b0);
      do_req($urandom % 4, $urandom % NT,
             ($urandom % 10 == 0) ? ROWS + ($urandom % 8) : $urandom % 3,
             ($urandom % 10 == 0) ? COLS + ($urandom % 8) : $urandom % 3,
             $urandom % 4, $urandom % 4, $urandom % 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
